sd_block_drainer: RTL and testbench
===================================

Name: sd_block_drainer

Overview:
- Read-side consumer of the SRAM-backed byte FIFO (`myfifo`).
- On `start`, pops exactly BLOCK_BYTES bytes from the FIFO and streams them over a valid/ready byte interface toward the SD data-line serializer.
- Computes CRC16 (poly 0x1021, init 0x0000, MSB-first) over the block and appends the CRC as two trailing bytes, high byte first.
- Owns the FIFO's r_enable; only observes the FIFO's write activity.

Parameters:
- BUS_WIDTH, 8, data width in bits. Only 8 is supported; the CRC logic is byte-wise.
- BLOCK_BYTES, 512, payload bytes per block. Range 1..1023.
- CNT_BITS, 10, width of the payload byte counter. Must satisfy 2^CNT_BITS > BLOCK_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to send a block; ignored unless state is IDLE.
- abort  in  1  synchronous cancel; takes priority over everything except n_rst.
- fifo_empty  in  1  FIFO empty flag.
- fifo_wbusy  in  1  FIFO's w_enable. While high, the SRAM address is the write pointer, so fifo_rdata is invalid.
- fifo_rdata  in  BUS_WIDTH  FIFO head data, valid combinationally when fifo_empty=0 and fifo_wbusy=0.
- fifo_r_enable  out  1  pop strobe to the FIFO.
- fifo_clear  out  1  one-cycle pulse on abort; flushes the FIFO pointers.
- tx_data  out  BUS_WIDTH  output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts the byte when tx_valid and tx_ready are both high at a clock edge.
- tx_last  out  1  high with the final CRC byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last CRC byte is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, CRC 0x0000, output register empty.
- States:
  - IDLE: on start → DATA. Clears the counter and CRC on the same edge.
  - DATA: pops payload bytes. After pop number BLOCK_BYTES → CRC_HI.
  - CRC_HI: once the output register is free, loads crc[15:8] → CRC_LO.
  - CRC_LO: once the output register is free, loads crc[7:0] with tx_last=1 → DRAIN.
  - DRAIN: waits for the last byte to be accepted, then pulses done → IDLE.
- Output register: single stage. Definitions:
  - free = !tx_valid | (tx_valid & tx_ready).
  - pop = (state==DATA) & !fifo_empty & !fifo_wbusy & free & (count < BLOCK_BYTES).
- On pop:
  - fifo_r_enable=1 (combinational, same cycle).
  - On the edge, tx_data ← fifo_rdata, tx_valid ← 1, CRC ← crc16_next(CRC, fifo_rdata), count ← count+1.
- Latency: first tx_valid rises 1 cycle after pop. With the FIFO non-empty, no writes and tx_ready held at 1:
  - sustained throughput is 1 byte/cycle;
  - a full block completes in BLOCK_BYTES+3 cycles from start to done (payload pops, CRC_HI, CRC_LO, DRAIN accept).
- tx_valid clears on acceptance unless a new byte is loaded on the same edge.
- tx_data and tx_last are held stable while tx_valid=1 and tx_ready=0.
- fifo_wbusy=1 blocks the pop in that cycle only; popping resumes the next cycle with no byte lost or duplicated.
- fifo_empty mid-block: DATA stalls indefinitely with tx_valid dropping after acceptance. There is no timeout.
- start while busy: ignored.
- start and abort in the same cycle from IDLE: abort wins, state stays IDLE.
- abort in any state:
  - next edge → IDLE, with tx_valid=0, tx_last=0, counter 0 and CRC 0;
  - fifo_clear=1 for exactly that cycle;
  - fifo_r_enable=0 in the abort cycle;
  - done is not asserted.
- Asynchronous reset mid-block: immediate return to reset values. The FIFO pointers are not touched by this block.
- CRC: 16-bit register, update per byte, no final XOR.

Decomposition:
- Package sd_tx_pkg:
  - state enum type (IDLE, DATA, CRC_HI, CRC_LO, DRAIN);
  - localparam CRC16_POLY = 16'h1021;
  - function crc16_next(logic [15:0] crc, logic [7:0] d), 8-iteration MSB-first shift.
- Sub-module sd_crc16_byte: registered accumulator with ports clk, n_rst, clear, en, din[7:0], crc[15:0]. The drainer instantiates one copy.

Test Plan:
- BLOCK_BYTES=9, FIFO preloaded with ASCII "123456789", tx_ready=1, start pulse → bytes 0x31..0x39 in order, then 0x31, 0xC3 with tx_last on 0xC3, done one cycle after; total 12 cycles from start.
- BLOCK_BYTES=512, 512×0xFF preloaded, tx_ready=1 → CRC bytes 0x7F, 0xA1; exactly 512 fifo_r_enable pulses; busy falls with done.
- Random tx_ready (50%) on the 9-byte block → identical byte sequence, and tx_data stable on every valid&!ready cycle.
- fifo_wbusy forced high every third cycle and fifo_empty high for cycles 3..7 mid-block → no fifo_r_enable during those cycles; output sequence and CRC unchanged versus the first scenario.
- abort asserted after the 4th payload byte → fifo_clear pulse of 1 cycle, next cycle state IDLE with tx_valid=0 and no done. A following start after refill sends a correct full block with CRC 0x31C3.
- start pulsed during DATA, and start+abort together in IDLE → no state change and no extra pops.

Source files
------------

// File: rtl/sd_tx_pkg.sv
// Shared types and the byte-wise CRC16 step for the SD block transmit path.
package sd_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CRC_HI,
        CRC_LO,
        DRAIN
    } tx_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One byte through the CRC16 LFSR, most significant bit first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i])
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc16_byte.sv
// Registered CRC16 accumulator, one byte per enabled cycle; clear wins over en.
module sd_crc16_byte
    import sd_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            crc <= 16'h0000;
        else if (clear)
            crc <= 16'h0000;
        else if (en)
            crc <= crc16_next(crc, din);
    end

endmodule

// File: rtl/sd_block_drainer.sv
// Pops one block from the byte FIFO, streams it on valid/ready and appends CRC16 (high byte first).
module sd_block_drainer
    import sd_tx_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int BLOCK_BYTES = 512,
    parameter int CNT_BITS    = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 fifo_empty,
    input  logic                 fifo_wbusy,
    input  logic [BUS_WIDTH-1:0] fifo_rdata,
    output logic                 fifo_r_enable,
    output logic                 fifo_clear,
    output logic [BUS_WIDTH-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_BITS-1:0] BLOCK_CNT = CNT_BITS'(BLOCK_BYTES);
    localparam logic [CNT_BITS-1:0] LAST_CNT  = CNT_BITS'(BLOCK_BYTES - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_BITS-1:0]  count_q;
    logic [BUS_WIDTH-1:0] data_p1;
    logic                 vld_p1;
    logic                 last_p1;
    logic                 done_q;
    logic [15:0]          crc;

    logic free, accept, pop, load_hi, load_lo, crc_clear;

    assign free    = !vld_p1 | tx_ready;
    assign accept  = vld_p1 & tx_ready;
    assign pop     = (state_q == DATA) & !fifo_empty & !fifo_wbusy & free
                   & (count_q < BLOCK_CNT) & !abort;
    assign load_hi = (state_q == CRC_HI) & free & !abort;
    assign load_lo = (state_q == CRC_LO) & free & !abort;
    // Starting a block and aborting both leave the accumulator at its init value.
    assign crc_clear = abort | ((state_q == IDLE) & start);

    sd_crc16_byte u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (crc_clear),
        .en    (pop),
        .din   (fifo_rdata),
        .crc   (crc)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = DATA;
                DATA:    if (pop && count_q == LAST_CNT) state_d = CRC_HI;
                CRC_HI:  if (free) state_d = CRC_LO;
                CRC_LO:  if (free) state_d = DRAIN;
                DRAIN:   if (accept) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Stage p1: single output register toward the serializer
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            count_q <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) & accept;
            if ((state_q == IDLE) && start)
                count_q <= '0;
            else if (pop)
                count_q <= count_q + CNT_BITS'(1);

            if (pop) begin
                data_p1 <= fifo_rdata;
                vld_p1  <= 1'b1;
                last_p1 <= 1'b0;
            end else if (load_hi) begin
                data_p1 <= crc[15:8];
                vld_p1  <= 1'b1;
                last_p1 <= 1'b0;
            end else if (load_lo) begin
                data_p1 <= crc[7:0];
                vld_p1  <= 1'b1;
                last_p1 <= 1'b1;
            end else if (accept) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    assign fifo_r_enable = pop;
    assign fifo_clear    = abort;
    assign tx_data       = data_p1;
    assign tx_valid      = vld_p1;
    assign tx_last       = last_p1;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_sd_block_drainer.sv
// Bench for sd_block_drainer: FIFO model, bit-serial CRC reference and a per-cycle stream checker.
module tb_sd_block_drainer;

    localparam int BLK = 9;
    localparam int BIG = 512;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // CRC16-CCITT as polynomial division, one message bit at a time.
    function automatic logic [15:0] lfsr_bit(input logic [15:0] r, input logic b);
        logic fb;
        fb = r[15] ^ b;
        return {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_byte(input logic [15:0] r, input logic [7:0] b);
        logic [15:0] x;
        x = r;
        for (int j = 7; j >= 0; j--) x = lfsr_bit(x, b[j]);
        return x;
    endfunction

    // Instance A: 9-byte blocks
    logic       start_a = 1'b0, abort_a = 1'b0, wbusy_a = 1'b0, force_empty_a = 1'b0, ready_a = 1'b1;
    logic       empty_a, ren_a, clr_a, valid_a, last_a, busy_a, done_a;
    logic [7:0] rdata_a, data_a;
    logic [7:0] mem_a [0:1023];
    int         rp_a = 0, wp_a = 0;

    assign empty_a = (rp_a == wp_a) | force_empty_a;
    assign rdata_a = mem_a[rp_a[9:0]];

    always @(posedge clk) begin
        if (clr_a)      rp_a <= wp_a;
        else if (ren_a) rp_a <= rp_a + 1;
    end

    sd_block_drainer #(.BUS_WIDTH(8), .BLOCK_BYTES(BLK), .CNT_BITS(10)) u_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .abort(abort_a),
        .fifo_empty(empty_a), .fifo_wbusy(wbusy_a), .fifo_rdata(rdata_a),
        .fifo_r_enable(ren_a), .fifo_clear(clr_a),
        .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a), .tx_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    // Instance B: 512-byte block, free-running sink
    logic       start_b = 1'b0;
    logic       empty_b, ren_b, clr_b, valid_b, last_b, busy_b, done_b;
    logic [7:0] rdata_b, data_b;
    logic [7:0] mem_b [0:1023];
    int         rp_b = 0, wp_b = 0;

    assign empty_b = (rp_b == wp_b);
    assign rdata_b = mem_b[rp_b[9:0]];

    always @(posedge clk) begin
        if (clr_b)      rp_b <= wp_b;
        else if (ren_b) rp_b <= rp_b + 1;
    end

    sd_block_drainer #(.BUS_WIDTH(8), .BLOCK_BYTES(BIG), .CNT_BITS(10)) u_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .abort(1'b0),
        .fifo_empty(empty_b), .fifo_wbusy(1'b0), .fifo_rdata(rdata_b),
        .fifo_r_enable(ren_b), .fifo_clear(clr_b),
        .tx_data(data_b), .tx_valid(valid_b), .tx_ready(1'b1), .tx_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    int         pops_b = 0;
    logic [7:0] got_b[$];
    logic       last_seen_b = 1'b0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (ren_b) pops_b++;
            if (valid_b) begin
                got_b.push_back(data_b);
                last_seen_b = last_b;
            end
        end
    end

    // Block model for instance A: expected bytes, busy/done timing, pop gating, stall stability
    logic [7:0] exp_q[$];
    bit         mbusy = 0, exp_done = 0, hold = 0;
    logic [7:0] held_d = 8'h00;
    logic       held_l = 1'b0;
    int         blk_pops = 0, acc_cnt = 0;

    always @(negedge clk) begin
        if (n_rst) begin
            bit         nxt_done;
            bit         allowed;
            logic [7:0] e;
            logic [15:0] r;
            nxt_done = 0;
            chk("busy", 32'(busy_a), 32'(mbusy));
            chk("done", 32'(done_a), 32'(exp_done));
            if (done_a) chk("pops_per_block", 32'(blk_pops), 32'(BLK));
            chk("fifo_clear", 32'(clr_a), 32'(abort_a));
            allowed = mbusy && !wbusy_a && !empty_a && !abort_a;
            if (!allowed) chk("pop_gate", 32'(ren_a), 32'd0);
            if (ren_a) blk_pops++;
            if (!mbusy) chk("idle_valid", 32'(valid_a), 32'd0);
            if (hold) begin
                chk("hold_valid", 32'(valid_a), 32'd1);
                chk("hold_data", 32'(data_a), 32'(held_d));
                chk("hold_last", 32'(last_a), 32'(held_l));
            end
            if (valid_a && ready_a) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 32'(data_a), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(data_a), 32'(e));
                    chk("tx_last", 32'(last_a), 32'(exp_q.size() == 0));
                    acc_cnt++;
                    if (exp_q.size() == 0 && !abort_a) nxt_done = 1;
                end
            end
            hold   = valid_a && !ready_a && !abort_a;
            held_d = data_a;
            held_l = last_a;
            exp_done = nxt_done;
            if (abort_a) begin
                mbusy = 0;
                exp_q.delete();
            end else if (!mbusy && start_a) begin
                mbusy = 1;
                blk_pops = 0;
                acc_cnt = 0;
                exp_q.delete();
                r = 16'h0000;
                for (int i = 0; i < BLK; i++) begin
                    exp_q.push_back(mem_a[10'(rp_a + i)]);
                    r = lfsr_byte(r, mem_a[10'(rp_a + i)]);
                end
                exp_q.push_back(r[15:8]);
                exp_q.push_back(r[7:0]);
            end else if (nxt_done) begin
                mbusy = 0;
            end
        end
    end

    task automatic fill_digits();
        for (int i = 0; i < BLK; i++) begin
            mem_a[10'(wp_a)] = 8'(8'h31 + i);
            wp_a = wp_a + 1;
        end
    endtask

    // mode: 0 plain, 1 random ready, 2 wbusy/empty disturbance, 3 extra start mid-block
    task automatic run_block(input int mode, output int cyc);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cyc = 0;
        while (1) begin
            ready_a       = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            wbusy_a       = (mode == 2) && (cyc % 3 == 0);
            force_empty_a = (mode == 2) && (cyc >= 3) && (cyc <= 7);
            start_a       = (mode == 3) && (cyc == 3);
            @(negedge clk);
            if (done_a) break;
            if (cyc > 300) begin
                chk("done_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        ready_a = 1'b1; wbusy_a = 1'b0; force_empty_a = 1'b0; start_a = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [15:0] r;
        logic        prev_busy;
        logic [7:0]  digits[9];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_last", 32'(last_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ren", 32'(ren_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        n_rst = 1'b1;

        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        r = 16'h0000;
        foreach (digits[i]) r = lfsr_byte(r, digits[i]);
        chk("model_crc_pin", 32'(r), 32'h31C3);

        // "123456789" with tx_ready held high
        fill_digits();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        chk("exp_len", 32'(exp_q.size()), 32'd11);
        chk("exp_crc_hi", 32'(exp_q[9]), 32'h31);
        chk("exp_crc_lo", 32'(exp_q[10]), 32'hC3);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (done_a || cyc > 300) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency_start_to_done", 32'(cyc), 32'd12);
        @(posedge clk); #1;

        // 512 x 0xFF on the large instance
        for (int i = 0; i < BIG; i++) begin
            mem_b[10'(wp_b)] = 8'hFF;
            wp_b = wp_b + 1;
        end
        r = 16'h0000;
        for (int i = 0; i < BIG; i++) r = lfsr_byte(r, 8'hFF);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = 0;
        prev_busy = 1'b0;
        while (1) begin
            @(negedge clk); #1;
            if (done_b || cyc > 2000) break;
            prev_busy = busy_b;
            @(posedge clk); #1;
            cyc++;
        end
        chk("big_latency", 32'(cyc), 32'(BIG + 3));
        chk("big_pops", 32'(pops_b), 32'(BIG));
        chk("big_bytes", 32'(got_b.size()), 32'(BIG + 2));
        if (got_b.size() == BIG + 2) begin
            chk("big_crc_hi", 32'(got_b[BIG]), 32'(r[15:8]));
            chk("big_crc_lo", 32'(got_b[BIG + 1]), 32'(r[7:0]));
        end
        chk("big_last", 32'(last_seen_b), 32'd1);
        chk("big_busy_before_done", 32'(prev_busy), 32'd1);
        chk("big_busy_with_done", 32'(busy_b), 32'd0);

        // Random backpressure
        fill_digits();
        run_block(1, cyc);

        // Write-busy every third cycle plus an empty window
        fill_digits();
        run_block(2, cyc);

        // Abort after the 4th payload byte, then a clean block after refill
        fill_digits();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cyc = 0;
        while (1) begin
            @(negedge clk); #1;
            if (acc_cnt >= 4) break;
            if (cyc > 100) begin
                chk("abort_wait_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1 abort_a = 1'b1;
        @(negedge clk);
        chk("abort_clear", 32'(clr_a), 32'd1);
        chk("abort_no_pop", 32'(ren_a), 32'd0);
        @(posedge clk); #1 abort_a = 1'b0;
        @(negedge clk);
        chk("post_abort_busy", 32'(busy_a), 32'd0);
        chk("post_abort_valid", 32'(valid_a), 32'd0);
        chk("post_abort_last", 32'(last_a), 32'd0);
        chk("post_abort_done", 32'(done_a), 32'd0);
        chk("post_abort_flushed", 32'(wp_a - rp_a), 32'd0);
        fill_digits();
        run_block(0, cyc);
        chk("refill_latency", 32'(cyc), 32'd12);

        // Stray start while in DATA
        fill_digits();
        run_block(3, cyc);
        chk("midstart_latency", 32'(cyc), 32'd12);
        chk("midstart_no_extra_pop", 32'(wp_a - rp_a), 32'd0);

        // start and abort together from IDLE
        fill_digits();
        @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("start_abort_idle", 32'(busy_a), 32'd0);
        chk("start_abort_flushed", 32'(wp_a - rp_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
